// File: rtl/sum_arb_ctrl.sv
// sum_arb_ctrl: round-robin two-requester controller sequencing a 1+2+...+N datapath.
// Optional SUM_ARB_ABORT_ON_OVF_EN: saturate and finish early on the first accumulate overflow.
module sum_arb_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] val0,
    input  logic [W-1:0] val1,
    input  logic         mZero,
    input  logic         overflow,
    input  logic [W-1:0] total,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         busy,
    output logic [W-1:0] dp_value,
    output logic         set,
    output logic         rac,
    output logic         dec,
    output logic         cac
);
    typedef enum logic [2:0] {IDLE, GRANT, LOAD, CHECK, ACC, DEC, DONE} state_t;
    state_t state, next;
    logic win, last, ovf_acc, pick;
    logic [W-1:0] dp_q;
    // last holds the requester served most recently; reset to 1 so requester 0 wins first
    assign pick = (req0 && req1) ? ~last : req1;
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= next;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            win     <= 1'b0;
            last    <= 1'b1;
            ovf_acc <= 1'b0;
            dp_q    <= '0;
        end else begin
            if (state == IDLE && (req0 || req1)) win <= pick;
            if (state == GRANT) begin
                dp_q    <= win ? val1 : val0;
                ovf_acc <= 1'b0;
            end
            if (state == ACC && overflow) ovf_acc <= 1'b1;
            if (state == DONE) last <= win;
        end
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:  next = (req0 || req1) ? GRANT : IDLE;
            GRANT: next = LOAD;
            LOAD:  next = CHECK;
            CHECK: next = mZero ? DONE : ACC;
`ifdef SUM_ARB_ABORT_ON_OVF_EN
            ACC:   next = overflow ? DONE : DEC;
`else
            ACC:   next = DEC;
`endif
            DEC:   next = CHECK;
            DONE:  next = IDLE;
            default: next = IDLE;
        endcase
    end
    always_comb begin
        gnt0     = (state == GRANT) && !win;
        gnt1     = (state == GRANT) && win;
        done0    = (state == DONE) && !win;
        done1    = (state == DONE) && win;
        busy     = state != IDLE;
        set      = state == LOAD;
        rac      = state == LOAD;
        cac      = state == ACC;
        dec      = state == DEC;
        ovf      = (state == DONE) && ovf_acc;
        dp_value = dp_q;
`ifdef SUM_ARB_ABORT_ON_OVF_EN
        result   = (state != DONE) ? '0 : ovf_acc ? '1 : total;
`else
        result   = (state == DONE) ? total : '0;
`endif
    end
endmodule

// File: doc/sum_arb_ctrl.md
SUM_ARB_CTRL -- requirements
Module: sum_arb_ctrl

Interface
REQ-001 SHALL have parameter W, default 8: operand, total and result width.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1: reset, synchronous and active-low.
REQ-004 SHALL have ports req0/req1  in  1: job request per requester, held high until grant.
REQ-005 SHALL have ports val0/val1  in  W: operand N per requester, stable while req high.
REQ-006 SHALL have ports gnt0/gnt1  out  1: one-cycle acceptance pulse per requester.
REQ-007 SHALL have ports done0/done1  out  1: one-cycle completion pulse per requester.
REQ-008 SHALL have port result  out  W: sum 1+2+...+N; valid only while a done pulse is high.
REQ-009 SHALL have port ovf  out  1: overflow flag; valid only while a done pulse is high.
REQ-010 SHALL have port busy  out  1: high from the grant cycle through the done cycle.
REQ-011 SHALL have port dp_value  out  W: operand driven to the datapath.
REQ-012 SHALL have ports set, rac, dec, cac  out  1: datapath controls (load counter, clear accumulator, decrement counter, accumulate counter into total).
REQ-013 SHALL have ports mZero  in  1 (datapath counter == 0), overflow  in  1 (accumulate carry-out) and total  in  W (accumulator value).

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, LOAD, CHECK, ACC, DEC, DONE.
REQ-015 IDLE: sample req0/req1; with any request pending, go to GRANT; otherwise remain in IDLE.
REQ-016 Arbitration SHALL be round-robin: a lone request wins; on simultaneous requests the requester not served last wins; after reset requester 0 has priority.
REQ-017 GRANT: pulse the winner's gnt for 1 cycle, latch its val into dp_value and record the winner; go to LOAD.
REQ-018 LOAD: assert set and rac together for 1 cycle; go to CHECK.
REQ-019 CHECK: no controls asserted; if mZero go to DONE, else go to ACC.
REQ-020 ACC: assert cac for 1 cycle; go to DEC.
REQ-021 DEC: assert dec for 1 cycle; go to CHECK.
REQ-022 DONE: drive result=total and ovf, pulse the winner's done for 1 cycle, update the last-served pointer; go to IDLE.
REQ-023 Latency SHALL be exactly 3N+3 cycles from the gnt cycle to the done cycle (N=0 gives 3).
REQ-024 At most one of set/rac (as a pair), cac and dec SHALL be high in any cycle; all are low in IDLE, GRANT, CHECK and DONE.
REQ-025 Requests SHALL be sampled only in IDLE; a req dropped before gnt creates no job; a request arriving while busy waits.
REQ-026 ovf SHALL be the OR of overflow over every ACC cycle of the current job and SHALL clear at GRANT.
REQ-027 The first IDLE cycle after DONE SHALL sample requests, so back-to-back jobs have 1 idle cycle between them.

Reset
REQ-028 With rst low at a clock edge: state SHALL become IDLE, last-served pointer SHALL favour requester 0, ovf accumulator SHALL clear.
REQ-029 While in reset, gnt0, gnt1, done0, done1, busy, set, rac, dec, cac, ovf SHALL be 0 and result and dp_value SHALL be 0.
REQ-030 Reset mid-job SHALL abort the job; no done pulse SHALL be issued for it.

Configuration
REQ-031 Macro SUM_ARB_ABORT_ON_OVF_EN defined: overflow high in ACC SHALL go directly to DONE next cycle with ovf=1 and result = all ones (saturated).
REQ-032 Macro SUM_ARB_ABORT_ON_OVF_EN undefined: the job SHALL run to mZero, result = total modulo 2^W, and ovf is sticky per REQ-026.

Verification
REQ-033 Lone request, N=4 -> gnt0 pulse; done0 exactly 15 cycles later; result=10, ovf=0.
REQ-034 Lone request, N=0 -> done1 3 cycles after gnt1; result=0, ovf=0; no cac or dec ever asserted.
REQ-035 After reset, req0 (N=3) and req1 (N=5) raised in the same cycle -> gnt0 first (result 6), then gnt1 (result 15); a repeat of the pair after req0 served alone -> gnt1 first.
REQ-036 N=23, W=8 -> macro defined: ovf=1, result=8'hFF, early done; macro undefined: ovf=1, result=20 at 3*23+3 cycles.
REQ-037 rst driven low during an ACC state of an N=6 job -> next cycle all outputs 0, no done; a new req0 after release is granted normally.
REQ-038 Every run: bench checks mutual exclusion of controls (REQ-024) and that gnt/done each pulse exactly once per job.
